// File: rtl/pwm_multichannel_if.sv
// Duty-cycle write port of the multi-channel PWM block.
// The register bank drives it through the master modport, and the PWM core samples it through the slave modport.
interface pwm_multichannel_if #(
  parameter int unsigned CHANNELS  = 16,
  parameter int unsigned CNT_WIDTH = 8
) ();
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 wr_en;
  logic [CH_W-1:0]      wr_ch;
  logic [CNT_WIDTH-1:0] wr_duty;

  modport master (output wr_en, output wr_ch, output wr_duty);
  modport slave  (input  wr_en, input  wr_ch, input  wr_duty);
endinterface

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM with a shared prescaler and period counter.
// Each channel has a double-buffered duty cycle, output gating and polarity.
module pwm_multichannel #(
  parameter int unsigned CHANNELS       = 16,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned PRESCALE_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pwm_multichannel_if.slave         wr_if,
  input  logic [CHANNELS-1:0]       en_out_i,
  input  logic [CHANNELS-1:0]       en_pwm_i,
  input  logic [CHANNELS-1:0]       polarity_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic [CHANNELS-1:0]       out_o,
  output logic                      period_start_o
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]      pending_q [CHANNELS];
  logic [CNT_WIDTH-1:0]      pending_d [CHANNELS];
  logic [CNT_WIDTH-1:0]      active_q  [CHANNELS];
  logic [CNT_WIDTH-1:0]      active_d  [CHANNELS];
  logic [CHANNELS-1:0]       out_d;
  logic [CHANNELS-1:0]       raw_c;
  logic                      tick_c;
  logic                      wrap_c;
  logic                      wr_hit_c;

  // Using >= lets a lowered prescale take effect at once instead of wrapping the prescaler.
  always_comb begin
    tick_c = (pre_q >= prescale_i);
    pre_d  = tick_c ? '0 : pre_q + PRESCALE_WIDTH'(1);
    cnt_d  = tick_c ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    wrap_c = tick_c && (&cnt_q);
  end

  // A write coinciding with the wrap is passed straight through to the active value.
  always_comb begin
    wr_hit_c = wr_if.wr_en && (32'(wr_if.wr_ch) < CHANNELS);
    for (int i = 0; i < CHANNELS; i++) begin
      pending_d[i] = pending_q[i];
      if (wr_hit_c && (wr_if.wr_ch == CH_W'(i))) begin
        pending_d[i] = wr_if.wr_duty;
      end
      active_d[i] = wrap_c ? pending_d[i] : active_q[i];
    end
  end

  // Compare against next-state values so that out_o stays aligned with cnt_q.
  always_comb begin
    raw_c = '0;
    out_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      raw_c[i] = !en_pwm_i[i] || (&active_d[i]) || (cnt_d < active_d[i]);
      out_d[i] = (en_out_i[i] & raw_c[i]) ^ polarity_i[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q          <= '0;
      cnt_q          <= '0;
      out_o          <= '0;
      period_start_o <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        pending_q[i] <= '0;
        active_q[i]  <= '0;
      end
    end else begin
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      out_o          <= out_d;
      period_start_o <= wrap_c;
      for (int i = 0; i < CHANNELS; i++) begin
        pending_q[i] <= pending_d[i];
        active_q[i]  <= active_d[i];
      end
    end
  end
endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed scoreboard bench for pwm_multichannel.
// CHANNELS is set to 12 so that out-of-range channel indices can be driven.
module tb_pwm_multichannel;
  localparam int unsigned CH  = 12;
  localparam int unsigned CW  = 8;
  localparam int unsigned PW  = 12;
  localparam int unsigned CHW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] en_out;
  logic [CH-1:0] en_pwm;
  logic [CH-1:0] polarity;
  logic [PW-1:0] prescale;
  logic [CH-1:0] out;
  logic          period_start;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          hi[CH];

  always #5 clk = ~clk;

  pwm_multichannel_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) wr_if ();

  pwm_multichannel #(
    .CHANNELS(CH), .CNT_WIDTH(CW), .PRESCALE_WIDTH(PW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_if         (wr_if),
    .en_out_i      (en_out),
    .en_pwm_i      (en_pwm),
    .polarity_i    (polarity),
    .prescale_i    (prescale),
    .out_o         (out),
    .period_start_o(period_start)
  );

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s: observed %0d but no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
    end
  endtask

  task automatic write(input int ch, input int duty);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_ch   = CHW'(ch);
    wr_if.wr_duty = CW'(duty);
    @(negedge clk);
    wr_if.wr_en   = 1'b0;
  endtask

  // Returns the number of clocks until period_start is seen.
  task automatic wait_ps(input string tag, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < budget);
    n_checks++;
    assert (period_start === 1'b1) else begin
      n_errors++;
      $error("FAIL %s: observed no period_start within %0d clocks", tag, budget);
    end
  endtask

  // Counts high clocks per channel over n clocks and optionally issues one write at step wr_at.
  task automatic measure(input int n, input int wr_at, input int wr_c, input int wr_d);
    for (int c = 0; c < CH; c++) hi[c] = 0;
    for (int k = 0; k < n; k++) begin
      if (k == wr_at) begin
        wr_if.wr_en   = 1'b1;
        wr_if.wr_ch   = CHW'(wr_c);
        wr_if.wr_duty = CW'(wr_d);
      end else begin
        wr_if.wr_en = 1'b0;
      end
      for (int c = 0; c < CH; c++) if (out[c]) hi[c]++;
      @(negedge clk);
    end
    wr_if.wr_en = 1'b0;
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    polarity      = '1;
    en_out        = '0;
    en_pwm        = '0;
    prescale      = '0;
    wr_if.wr_en   = 1'b0;
    wr_if.wr_ch   = '0;
    wr_if.wr_duty = '0;

    // Reset with inverted polarity: outputs stay low until released.
    repeat (5) @(negedge clk);
    push(0); check("rst_out", 32'(out));
    push(0); check("rst_ps", 32'(period_start));
    rst_n = 1'b1;
    @(negedge clk);
    push(32'hFFF); check("post_rst_out", 32'(out));

    // Basic duty and the extreme cases.
    polarity = 12'h010;
    en_out   = 12'h01F;
    en_pwm   = 12'h017;
    write(0, 128); write(1, 0); write(2, 255); write(4, 64);
    push(128); push(0); push(256); push(256); push(192);
    wait_ps("ps_first", 600, n);
    measure(256, -1, 0, 0);
    check("duty128", 32'(hi[0]));
    check("duty0", 32'(hi[1]));
    check("duty255", 32'(hi[2]));
    check("const_high", 32'(hi[3]));
    check("pol_duty64", 32'(hi[4]));
    push(1); check("ps_interval", 32'(period_start));

    // Buffered update, a write coinciding with the wrap, and an out-of-range channel write.
    write(0, 200);
    wait_ps("ps_buf", 600, n);
    push(200); push(50); push(30); push(30);
    measure(256, 100, 0, 50);  check("buf_old", 32'(hi[0]));
    measure(256, 255, 0, 30);  check("buf_new", 32'(hi[0]));
    measure(256, 10, 12, 200); check("wrap_write", 32'(hi[0]));
    measure(256, -1, 0, 0);    check("bad_ch", 32'(hi[0]));

    // Prescaler of 3 gives 1024-clock periods.
    prescale = 12'd3;
    write(0, 10);
    wait_ps("ps_pre", 3000, n);
    push(40); push(1);
    measure(1024, -1, 0, 0);
    check("pre_duty", 32'(hi[0]));
    check("pre_period", 32'(period_start));

    // Lowering prescale below pre ticks on the very next clock.
    @(negedge clk); @(negedge clk);
    prescale = 12'd0;
    wait_ps("ps_drop", 6000, n);
    push(256); check("pre_drop", 32'(n));

    // Asynchronous reset mid-period at cnt=77.
    repeat (77) @(negedge clk);
    polarity = '1;
    #2 rst_n = 1'b0;
    #1;
    push(0); check("async_out", 32'(out));
    push(0); check("async_ps", 32'(period_start));
    @(negedge clk); @(negedge clk);
    polarity = '0;
    en_out   = 12'h009;
    en_pwm   = 12'h001;
    rst_n    = 1'b1;
    wait_ps("ps_restart", 600, n);
    push(256); check("restart", 32'(n));
    push(0); push(256);
    measure(256, -1, 0, 0);
    check("rst_duty0", 32'(hi[0]));
    check("rst_const", 32'(hi[3]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised multi-channel PWM generator, the next-generation replacement for the fixed 16-output, single-duty PWM peripheral behind the SPI register bank. It provides a programmable clock prescaler and a per-channel duty cycle with double-buffered, glitch-free updates at period boundaries. It also adds per-channel output polarity and a period-start strobe for software and test synchronisation. The SPI register interface drives its write port and enable/polarity vectors, and its outputs map directly to `uo_out`/`uio_out`.

## Interface
- `CHANNELS`, default 16: number of PWM outputs, range 1–32.
- `CNT_WIDTH`, default 8: period counter and duty width; the period is 2^CNT_WIDTH ticks.
- `PRESCALE_WIDTH`, default 12: prescaler width.

- `clk`  in  1: single clock; all state on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en_out`  in  CHANNELS: per-channel output enable; 0 forces the pin's raw level to 0 before polarity.
- `en_pwm`  in  CHANNELS: per-channel mode; 1 selects PWM, 0 selects constant high before polarity.
- `polarity`  in  CHANNELS: 1 inverts the channel output after gating.
- `prescale`  in  PRESCALE_WIDTH: tick divider; one tick every `prescale`+1 clocks.
- `wr_en`  in  1: duty write strobe, one-cycle pulse.
- `wr_ch`  in  max(1,$clog2(CHANNELS)): channel index for the write.
- `wr_duty`  in  CNT_WIDTH: duty value for the write.
- `out`  out  CHANNELS: registered PWM outputs.
- `period_start`  out  1: one-clock pulse at the start of each PWM period.

## Operation
- **Prescaler (`pre`)**
  - On each clock: if `pre` >= `prescale`, then `tick`=1 and `pre`←0; else `pre`←`pre`+1.
  - The >= comparison means that lowering `prescale` below the current `pre` produces a tick on the next clock, with no long wrap.
- **Period counter (`cnt`)**
  - Advances only on `tick`, wrapping from 2^CNT_WIDTH−1 to 0.
  - `wrap` = `tick` && `cnt`==all-ones.
- **Duty double-buffer**
  - Each channel has `pending` and `active` registers.
  - A write with `wr_en`=1 and `wr_ch` < CHANNELS loads `pending[wr_ch]`.
  - A write with `wr_ch` >= CHANNELS is ignored.
  - On `wrap`, every `active[i]` ← `pending[i]`.
  - If a write coincides with `wrap` on the same channel, the written value goes to both `pending` and `active`; the write takes effect in the period that is starting.
- **Raw level per channel**
  - `en_pwm[i]`=0: 1.
  - `active[i]`=all-ones: 1 (100 %).
  - Otherwise: (`cnt_next` < `active_next[i]`), where `_next` denotes the values being registered this cycle.
  - Duty 0 gives 0 %.
- **Output**
  - `out[i]` ← (`en_out[i]` ? raw : 0) ^ `polarity[i]`, registered.
  - A disabled channel with `polarity`=1 outputs 1. This is intended, so the board-level idle level can be chosen.
- `en_out`, `en_pwm`, `polarity` and `prescale` are not buffered; they take effect on the next clock edge.
- **`period_start`** ← `wrap`, registered. It is high exactly in the first clock in which `cnt`=0 for the new period.

## Timing
- **Reset values (asynchronous):** `pre`=0, `cnt`=0, all `pending`/`active`=0, `out`=0, `period_start`=0.
- The first tick occurs on the first clock after reset release.
- The period is (`prescale`+1)·2^CNT_WIDTH clocks.
- High time per period is `active`·(`prescale`+1) clocks for `active` < all-ones.
- `out` and `cnt` are aligned:
  - `out` reflects the new `cnt` value in the same clock that `cnt` updates.
  - There is no extra pipeline stage between them.
- **Write latency:** a duty change is visible at the next `period_start`, never mid-period, so no runt or extended pulses occur.
- `period_start` asserts for exactly 1 clock per period, including when `prescale`=0.
- A reset asserted mid-period clears everything immediately, without waiting for a clock edge. Outputs go low even if `polarity`=1, until the first clock after release.

## Test plan
- **Reset:** hold `rst_n`=0 for 5 clocks with `polarity`=all-ones → `out`=0 and `period_start`=0 during reset. After the first post-release clock, `out`=all-ones: `en_out`=0, inverted.
- **Basic duty:** `prescale`=0, write ch0 duty 128, `en_out`/`en_pwm` bit0=1 → after the next `period_start`, `out[0]` is high for 128 of every 256 clocks and `period_start` pulses every 256 clocks.
- **Extremes:** ch1 duty 0 → `out[1]` constantly 0. ch2 duty 255 → `out[2]` constantly 1. `en_pwm[3]`=0 → `out[3]`=1. `polarity[4]`=1 with duty 64 → `out[4]` low 64 and high 192 clocks per period.
- **Buffered update:** with ch0 at duty 200, write duty 50 at `cnt`=100 → the current period still shows 200 high clocks, and the next period shows 50. A write coincident with `wrap` takes effect in the period that starts immediately.
- **Prescaler:** `prescale`=3, duty 10 → period 1024 clocks with 40 high clocks. Change `prescale` from 3 to 0 while `pre`=2 → a tick occurs on the next clock.
- **Robustness:** `wr_ch`=CHANNELS write → no `pending` changes. Asynchronous reset at `cnt`=77 mid-run → all state cleared within the same cycle, and the block restarts from `cnt`=0 with duties 0.
